// File: rtl/pkt_seq_checker.sv
// Packet sequence checker: validates a fixed header and an incrementing sequence
// field on each accepted word, tracks lock status and counts bad words.
module pkt_seq_checker #(
  parameter int                   BUS_SIZE  = 16,
  parameter int                   WORD_SIZE = 4,
  parameter logic [WORD_SIZE-1:0] HDR_CODE  = {WORD_SIZE{1'b1}},
  parameter int                   LOCK_CNT  = 3,
  parameter int                   ERR_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                data_valid,
  input  logic [BUS_SIZE-1:0] data_bus,
  input  logic                err_clr,
  output logic                error,
  output logic                locked,
  output logic [ERR_W-1:0]    err_count,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_CHECK   = 3'd1,
    S_LOCKED  = 3'd2,
    S_F_ERR   = 3'd3,
    S_SEQ_ERR = 3'd4
  } state_t;

  localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);

  state_t               r_state;
  logic [WORD_SIZE-1:0] r_exp;
  logic [7:0]           r_gcnt;
  logic                 r_error;
  logic                 r_locked;
  logic [ERR_W-1:0]     r_err_count;

  state_t               w_state_next;
  logic [WORD_SIZE-1:0] w_exp_next;
  logic [7:0]           w_gcnt_next;
  logic                 w_error_next;
  logic                 w_err_evt;

  logic [WORD_SIZE-1:0] w_hdr;
  logic [WORD_SIZE-1:0] w_seq;
  logic                 w_hdr_ok;
  logic                 w_seq_ok;
  logic [7:0]           w_gcnt_inc;
  logic                 w_cnt_full;

  assign w_hdr      = data_bus[BUS_SIZE-1 -: WORD_SIZE];
  assign w_seq      = data_bus[WORD_SIZE-1:0];
  assign w_hdr_ok   = (w_hdr == HDR_CODE);
  assign w_seq_ok   = (w_seq == r_exp);
  assign w_gcnt_inc = r_gcnt + 8'd1;
  assign w_cnt_full = &r_err_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_HUNT;
      r_exp   <= '0;
      r_gcnt  <= '0;
      r_error <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_exp    <= w_exp_next;
      r_gcnt   <= w_gcnt_next;
      r_error  <= w_error_next;
      r_locked <= (w_state_next == S_LOCKED);
    end
  end

  // Clear has priority over a same-cycle error event.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (err_clr) begin
      r_err_count <= '0;
    end else if (w_err_evt && !w_cnt_full) begin
      r_err_count <= r_err_count + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_exp_next   = r_exp;
    w_gcnt_next  = r_gcnt;
    w_error_next = r_error;
    w_err_evt    = 1'b0;

    if (r_state > S_SEQ_ERR) begin
      w_state_next = S_HUNT;
    end else if (data_valid) begin
      if (!w_hdr_ok) begin
        // A bad header overrides any sequence result and keeps exp.
        w_state_next = S_F_ERR;
        w_error_next = 1'b1;
        w_gcnt_next  = '0;
        w_err_evt    = 1'b1;
      end else begin
        case (r_state)
          S_CHECK: begin
            if (w_seq_ok) begin
              w_exp_next   = r_exp + WORD_SIZE'(1);
              w_gcnt_next  = w_gcnt_inc;
              w_error_next = 1'b0;
              w_state_next = (w_gcnt_inc == LOCK_TGT) ? S_LOCKED : S_CHECK;
            end else begin
              w_state_next = S_SEQ_ERR;
              w_error_next = 1'b1;
              w_gcnt_next  = '0;
              w_err_evt    = 1'b1;
            end
          end
          S_LOCKED: begin
            if (w_seq_ok) begin
              w_exp_next   = r_exp + WORD_SIZE'(1);
              w_error_next = 1'b0;
              w_state_next = S_LOCKED;
            end else begin
              w_state_next = S_SEQ_ERR;
              w_error_next = 1'b1;
              w_gcnt_next  = '0;
              w_err_evt    = 1'b1;
            end
          end
          default: begin
            // Resync from HUNT, F_ERR or SEQ_ERR on the first good header.
            w_exp_next   = w_seq + WORD_SIZE'(1);
            w_gcnt_next  = 8'd1;
            w_error_next = 1'b0;
            w_state_next = (LOCK_TGT == 8'd1) ? S_LOCKED : S_CHECK;
          end
        endcase
      end
    end
  end

  assign error     = r_error;
  assign locked    = r_locked;
  assign err_count = r_err_count;
  assign state     = r_state;

endmodule

// File: tb/tb_pkt_seq_checker.sv
// Bench for pkt_seq_checker: directed vector table, hand-written corner
// sequences, then random traffic checked against a behavioural model.
module tb_pkt_seq_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_valid;
  logic [15:0] data_bus;
  logic        err_clr;
  logic        error;
  logic        locked;
  logic [7:0]  err_count;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  pkt_seq_checker #(
    .BUS_SIZE (16),
    .WORD_SIZE(4),
    .HDR_CODE (4'hF),
    .LOCK_CNT (3),
    .ERR_W    (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_valid(data_valid),
    .data_bus  (data_bus),
    .err_clr   (err_clr),
    .error     (error),
    .locked    (locked),
    .err_count (err_count),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          v;
    bit          clr;
    logic [15:0] bus;
    logic [2:0]  st;
    bit          er;
    bit          lk;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input bit rst, input bit v, input bit clr, input logic [15:0] bus);
    reset      = rst;
    data_valid = v;
    err_clr    = clr;
    data_bus   = bus;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int st, input int er, input int lk, input int cnt);
    $display("%s: rst=%0b v=%0b clr=%0b bus=%h -> state=%0d error=%0b locked=%0b err_count=%0h",
             tag, reset, data_valid, err_clr, data_bus, state, error, locked, err_count);
    chk({tag, ".state"}, int'(state), st);
    chk({tag, ".error"}, int'(error), er);
    chk({tag, ".locked"}, int'(locked), lk);
    chk({tag, ".err_count"}, int'(err_count), cnt);
  endtask

  // Behavioural model: alignment flag, run length of in-order words, last error kind.
  bit         m_synced;
  int         m_run;
  int         m_kind;
  int         m_exp;
  bit         m_err;
  int         m_cnt;

  task automatic model_reset();
    m_synced = 0; m_run = 0; m_kind = 0; m_exp = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit rst, input bit v, input bit clr, input logic [15:0] bus);
    bit evt;
    int seq;
    evt = 0;
    seq = int'(bus[3:0]);
    if (rst) begin
      model_reset();
      return;
    end
    if (v) begin
      if (bus[15:12] != 4'hF) begin
        m_synced = 0; m_kind = 3; m_err = 1; evt = 1;
      end else if (!m_synced) begin
        m_synced = 1; m_exp = (seq + 1) % 16; m_run = 1; m_err = 0;
      end else if (seq == m_exp) begin
        m_exp = (m_exp + 1) % 16;
        m_run = (m_run + 1 > 3) ? 3 : m_run + 1;
        m_err = 0;
      end else begin
        m_synced = 0; m_kind = 4; m_err = 1; evt = 1;
      end
    end
    if (clr) m_cnt = 0;
    else if (evt && m_cnt < 255) m_cnt = m_cnt + 1;
  endtask

  function automatic int model_state();
    if (m_synced) return (m_run >= 3) ? 2 : 1;
    return m_kind;
  endfunction

  initial begin
    reset = 1'b1; data_valid = 1'b0; err_clr = 1'b0; data_bus = '0;

    tbl[0]  = '{1, 0, 0, 16'h0000, 3'd0, 0, 0, 8'd0};
    tbl[1]  = '{0, 1, 0, 16'hF005, 3'd1, 0, 0, 8'd0};
    tbl[2]  = '{0, 1, 0, 16'hF006, 3'd1, 0, 0, 8'd0};
    tbl[3]  = '{0, 1, 0, 16'hF007, 3'd2, 0, 1, 8'd0};
    tbl[4]  = '{0, 1, 0, 16'hF00A, 3'd4, 1, 0, 8'd1};
    tbl[5]  = '{0, 1, 0, 16'hF00B, 3'd1, 0, 0, 8'd1};
    tbl[6]  = '{0, 1, 0, 16'hF00C, 3'd1, 0, 0, 8'd1};
    tbl[7]  = '{0, 1, 0, 16'hF00D, 3'd2, 0, 1, 8'd1};
    tbl[8]  = '{0, 1, 0, 16'h700C, 3'd3, 1, 0, 8'd2};
    tbl[9]  = '{0, 0, 0, 16'h0000, 3'd3, 1, 0, 8'd2};
    tbl[10] = '{0, 0, 0, 16'hF00E, 3'd3, 1, 0, 8'd2};
    tbl[11] = '{0, 1, 0, 16'hF00B, 3'd1, 0, 0, 8'd2};
    tbl[12] = '{0, 1, 0, 16'hF00C, 3'd1, 0, 0, 8'd2};
    tbl[13] = '{0, 1, 0, 16'hF00D, 3'd2, 0, 1, 8'd2};
    tbl[14] = '{0, 1, 0, 16'hF00E, 3'd2, 0, 1, 8'd2};
    tbl[15] = '{0, 1, 0, 16'hF00F, 3'd2, 0, 1, 8'd2};
    tbl[16] = '{0, 1, 0, 16'hF000, 3'd2, 0, 1, 8'd2};
    tbl[17] = '{0, 1, 0, 16'hF001, 3'd2, 0, 1, 8'd2};
    tbl[18] = '{0, 0, 0, 16'hF005, 3'd2, 0, 1, 8'd2};
    tbl[19] = '{0, 1, 0, 16'h3002, 3'd3, 1, 0, 8'd3};
    tbl[20] = '{0, 1, 1, 16'hF003, 3'd1, 0, 0, 8'd0};
    tbl[21] = '{0, 1, 1, 16'h1234, 3'd3, 1, 0, 8'd0};

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].clr, tbl[i].bus);
      chk_all($sformatf("vec%0d", i), int'(tbl[i].st), int'(tbl[i].er), int'(tbl[i].lk), int'(tbl[i].cnt));
    end

    // Saturation: 255 bad words fill the counter, one more must not wrap.
    for (int i = 0; i < 255; i++) drive(0, 1, 0, 16'h0000);
    chk_all("sat_full", 3, 1, 0, 8'hFF);
    drive(0, 1, 0, 16'h0001);
    chk_all("sat_hold", 3, 1, 0, 8'hFF);
    drive(0, 1, 1, 16'h0002);
    chk_all("clr_wins", 3, 1, 0, 8'h00);

    // Reset while locked with a valid word present.
    drive(0, 1, 0, 16'h0001);
    chk_all("pre_bad", 3, 1, 0, 8'h01);
    drive(0, 1, 0, 16'hF001);
    drive(0, 1, 0, 16'hF002);
    drive(0, 1, 0, 16'hF003);
    chk_all("pre_lock", 2, 0, 1, 8'h01);
    drive(1, 1, 0, 16'hF004);
    chk_all("rst_locked", 0, 0, 0, 8'h00);
    drive(0, 1, 0, 16'hF009);
    chk_all("post_rst_sync", 1, 0, 0, 8'h00);
    drive(0, 1, 0, 16'hF00A);
    drive(0, 1, 0, 16'hF00B);
    chk_all("post_rst_lock", 2, 0, 1, 8'h00);

    // Random traffic against the model.
    drive(1, 0, 0, 16'h0000);
    model_reset();
    for (int n = 0; n < 1000; n++) begin
      bit          r_rst;
      bit          r_v;
      bit          r_clr;
      logic [15:0] r_bus;
      r_rst = ($urandom_range(0, 99) < 2);
      r_v   = ($urandom_range(0, 99) < 75);
      r_clr = ($urandom_range(0, 99) < 3);
      r_bus = 16'($urandom);
      if ($urandom_range(0, 99) < 85) r_bus[15:12] = 4'hF;
      if ($urandom_range(0, 99) < 80) r_bus[3:0] = 4'(m_exp);
      drive(r_rst, r_v, r_clr, r_bus);
      model_step(r_rst, r_v, r_clr, r_bus);
      chk_all($sformatf("rnd%0d", n), model_state(), int'(m_err), (model_state() == 2) ? 1 : 0, m_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
